// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port main memory: CPU has priority,
// a streak counter guarantees the DBG port is served after STARVE_MAX CPU grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        fsm_state
);

  // Handshake: req is a level the requester holds; it is sampled only in IDLE.
  // ack is a one-cycle completion pulse and fires even if req was dropped mid-access.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
  localparam logic [2:0] WAIT_LAST  = 3'(RD_LAT - 1);

  state_t              state, state_nx;
  logic [3:0]          streak;
  logic [2:0]          wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                owner_q;
  logic                dbg_win, cpu_win, grant;

  always_comb begin
    dbg_win = dbg_req && (!cpu_req || (streak == STREAK_MAX));
    cpu_win = cpu_req && !dbg_win;
    grant   = (state == ST_IDLE) && (dbg_win || cpu_win);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cpu_req || dbg_req) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = lat_we ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Grant latches, streak accounting, wait counter and per-port read capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak    <= '0;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      owner_q   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grant) begin
        owner_q   <= dbg_win;
        lat_we    <= dbg_win ? dbg_we    : cpu_we;
        lat_addr  <= dbg_win ? dbg_addr  : cpu_addr;
        lat_wdata <= dbg_win ? dbg_wdata : cpu_wdata;
        if (dbg_win || !dbg_req)      streak <= '0;
        else if (streak < STREAK_MAX) streak <= streak + 4'd1;
      end
      if (state == ST_ISSUE)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 3'd1;
      if ((state == ST_WAIT) && (wait_cnt == WAIT_LAST)) begin
        if (owner_q) dbg_rdata <= mem_rdata;
        else         cpu_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = (state == ST_ISSUE);
    mem_we    = lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    cpu_ack   = (state == ST_ACK) && !owner_q;
    dbg_ack   = (state == ST_ACK) && owner_q;
    busy      = (state != ST_IDLE);
    owner     = owner_q;
    fsm_state = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model predicts each
// access and ack with its cycle stamp; a negedge monitor compares the DUT.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;

  logic              clock, reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic              cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        fsm_state;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F17;
  endfunction

  // ---------------- memory responder ----------------
  logic [DATA_W-1:0] mem  [0:511];
  logic [DATA_W-1:0] pipe [0:7];
  bit mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
    for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0) ? mem[mem_addr] : $urandom;
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic port; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } iss_t;
  typedef struct { int cyc; logic port; logic [DATA_W-1:0] cpu_rd; logic [DATA_W-1:0] dbg_rd; } ack_t;
  iss_t iss_q[$];
  ack_t ack_q[$];

  logic [DATA_W-1:0] ref_mem [0:511];
  bit                ref_ready = 1'b0;
  int                streak_m = 0;
  int                next_free = 0;
  int                ack_cyc;
  logic              exp_owner = 1'b0;
  logic [DATA_W-1:0] m_cpu_rd = '0, m_dbg_rd = '0;
  logic              g_port, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  always @(posedge clock) begin
    if (!ref_ready) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      ref_ready = 1'b1;
    end
    if (reset) begin
      streak_m = 0; next_free = cyc + 1; exp_owner = 1'b0;
      m_cpu_rd = '0; m_dbg_rd = '0;
      iss_q.delete(); ack_q.delete();
    end else if (cyc >= next_free && (cpu_req || dbg_req)) begin
      g_port  = dbg_req && (!cpu_req || streak_m == STARVE_MAX);
      g_we    = g_port ? dbg_we : cpu_we;
      g_addr  = g_port ? dbg_addr : cpu_addr;
      g_wdata = g_port ? dbg_wdata : cpu_wdata;
      if (g_port || !dbg_req) streak_m = 0;
      else if (streak_m < STARVE_MAX) streak_m = streak_m + 1;
      if (g_we) begin
        ref_mem[g_addr] = g_wdata;
        ack_cyc = cyc + 2;
      end else begin
        if (g_port) m_dbg_rd = ref_mem[g_addr];
        else        m_cpu_rd = ref_mem[g_addr];
        ack_cyc = cyc + 2 + RD_LAT;
      end
      iss_q.push_back('{cyc + 1, g_port, g_we, g_addr, g_wdata});
      ack_q.push_back('{ack_cyc, g_port, m_cpu_rd, m_dbg_rd});
      next_free = ack_cyc + 1;
      exp_owner = g_port;
    end
    cyc = cyc + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic grant_log[$];
  iss_t e;
  ack_t a;

  always @(negedge clock) begin
    if (check_en) begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        e = iss_q.pop_front();
        check("mem_en", mem_en, 1'b1);
        check("mem_we", mem_we, e.we);
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
        check("issue_owner", owner, e.port);
      end else begin
        check("mem_en_quiet", mem_en, 1'b0);
      end
      if (mem_en === 1'b1) grant_log.push_back(owner);
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        a = ack_q.pop_front();
        check("cpu_ack", cpu_ack, !a.port);
        check("dbg_ack", dbg_ack, a.port);
        check("cpu_rdata", cpu_rdata, a.cpu_rd);
        check("dbg_rdata", dbg_rdata, a.dbg_rd);
      end else begin
        check("cpu_ack_quiet", cpu_ack, 1'b0);
        check("dbg_ack_quiet", dbg_ack, 1'b0);
      end
      check("busy", busy, cyc < next_free);
      check("owner", owner, exp_owner);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_fields();
    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 9'($urandom_range(0, 511)); cpu_wdata = $urandom;
    dbg_we = 1'($urandom_range(0, 1)); dbg_addr = 9'($urandom_range(0, 511)); dbg_wdata = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (busy === 1'b0 && iss_q.size() == 0 && ack_q.size() == 0) done = 1'b1;
    end
    if (!done) check("wait_idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_owner"}, owner, 1'b0);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_cpu_rdata"}, cpu_rdata, '0);
    check({tag, "_dbg_rdata"}, dbg_rdata, '0);
    check({tag, "_acks"}, {cpu_ack, dbg_ack}, 2'b00);
    check({tag, "_state"}, fsm_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  logic exp_order [0:9];
  bit   got_ack;
  int   pct;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(posedge clock); @(negedge clock);
    check_en = 1'b1;
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    // Directed CPU write; inputs scrambled after the grant.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
    @(negedge clock);
    cpu_req = 1'b0; cpu_addr = 9'h1AA; cpu_wdata = 32'h0BAD0BAD;
    check("wr_mem_addr", mem_addr, 9'h005);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    wait_idle(20);
    check("wr_cpu_rdata_unchanged", cpu_rdata, 32'h0);

    // Directed CPU read of the same word.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    @(negedge clock);
    cpu_req = 1'b0; cpu_addr = 9'h0F0;
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clock);
      cpu_addr = 9'($urandom_range(0, 511)); cpu_wdata = $urandom;
    end
    wait_idle(20);
    check("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_dbg_rdata_unchanged", dbg_rdata, 32'h0);

    // Both ports hold req: starvation bound decides the grant order.
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    grant_log.delete();
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 200 && grant_log.size() < 10; i++) begin
      rand_fields();
      @(negedge clock);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_grant_count", 64'(grant_log.size() >= 10), 64'd1);
    if (grant_log.size() >= 10)
      for (int i = 0; i < 10; i++) check($sformatf("starve_order_%0d", i), grant_log[i], exp_order[i]);
    wait_idle(40);

    // CPU drops req right after its grant, DBG read waits behind it.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h033;
    @(negedge clock);
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h044;
    got_ack = 1'b0;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clock);
      if (dbg_ack === 1'b1) got_ack = 1'b1;
    end
    dbg_req = 1'b0;
    check("dbg_after_cpu_ack_seen", got_ack, 1'b1);
    check("dbg_rdata_value", dbg_rdata, init_word(9'h044));
    wait_idle(20);

    // Reset during the WAIT of a DBG read aborts it.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h077;
    @(negedge clock);
    dbg_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero("abort");
    repeat (RD_LAT + 3) @(negedge clock);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h077; dbg_wdata = 32'hCAFEF00D;
    @(negedge clock);
    dbg_req = 1'b0;
    check("post_reset_grant", {mem_en, owner}, 2'b11);
    wait_idle(20);

    // Randomized traffic with varying request density.
    for (int seg = 0; seg < 6; seg++) begin
      pct = (seg % 3 == 0) ? 95 : ((seg % 3 == 1) ? 40 : 15);
      for (int i = 0; i < 250; i++) begin
        cpu_req = ($urandom_range(0, 99) < pct);
        dbg_req = ($urandom_range(0, 99) < pct);
        rand_fields();
        @(negedge clock);
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    wait_idle(60);
    check("iss_q_drained", iss_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
